// File: rtl/sha256_round_ctrl_if.sv
// Host/datapath signal bundle for the SHA-256 round sequencer.
// With SHA256_CTRL_ABORT_EN defined the bundle also carries an abort request.
interface sha256_round_ctrl_if #(
    parameter int unsigned MAX_BLOCKS = 8,
    parameter int unsigned BLK_W      = $clog2(MAX_BLOCKS + 1),
    parameter int unsigned ADDR_W     = $clog2(MAX_BLOCKS * 16)
);
    logic              start;
    logic [BLK_W-1:0]  msg_blocks;
`ifdef SHA256_CTRL_ABORT_EN
    logic              abort;
`endif
    logic              msg_read_en;
    logic [ADDR_W-1:0] msg_read_addr;
    logic [5:0]        round_idx;
    logic              w_sel_msg;
    logic              hash_iv;
    logic              work_load;
    logic              round_en;
    logic              hash_add;
    logic              busy;
    logic              done;

`ifdef SHA256_CTRL_ABORT_EN
    modport master (
        output start, msg_blocks, abort,
        input  msg_read_en, msg_read_addr, round_idx, w_sel_msg,
               hash_iv, work_load, round_en, hash_add, busy, done
    );
    modport slave (
        input  start, msg_blocks, abort,
        output msg_read_en, msg_read_addr, round_idx, w_sel_msg,
               hash_iv, work_load, round_en, hash_add, busy, done
    );
`else
    modport master (
        output start, msg_blocks,
        input  msg_read_en, msg_read_addr, round_idx, w_sel_msg,
               hash_iv, work_load, round_en, hash_add, busy, done
    );
    modport slave (
        input  start, msg_blocks,
        output msg_read_en, msg_read_addr, round_idx, w_sel_msg,
               hash_iv, work_load, round_en, hash_add, busy, done
    );
`endif
endinterface

// File: rtl/sha256_round_ctrl.sv
// Sequencer for the SHA-256 compression datapath: IV load, per-block load, 64 rounds, hash add.
// Optional feature macro: SHA256_CTRL_ABORT_EN (adds an abort input that returns the FSM to IDLE).
module sha256_round_ctrl #(
    parameter int unsigned MAX_BLOCKS = 8,
    parameter int unsigned BLK_W      = $clog2(MAX_BLOCKS + 1),
    parameter int unsigned ADDR_W     = $clog2(MAX_BLOCKS * 16)
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    sha256_round_ctrl_if.slave   ctrl_bus
);

    localparam logic [BLK_W-1:0] MAX_BLK    = BLK_W'(MAX_BLOCKS);
    localparam logic [5:0]       LAST_ROUND = 6'd63;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_LOAD   = 3'd2,
        S_ROUND  = 3'd3,
        S_UPDATE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            r_state;
    logic [BLK_W-1:0]  r_blocks;
    logic [BLK_W-1:0]  r_blk_cnt;
    logic [5:0]        r_round_idx;
    logic              r_read_en;
    logic [ADDR_W-1:0] r_read_addr;
    logic              r_w_sel;
    logic              r_hash_iv;
    logic              r_work_load;
    logic              r_round_en;
    logic              r_hash_add;
    logic              r_busy;
    logic              r_done;

    logic [BLK_W-1:0]  w_blk_nxt;
    logic [5:0]        w_round_nxt;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_next_base;
    logic [BLK_W-1:0]  w_blocks_clamped;
    logic              w_abort;

    assign w_blk_nxt        = r_blk_cnt + BLK_W'(1);
    assign w_round_nxt      = r_round_idx + 6'd1;
    assign w_base           = ADDR_W'(r_blk_cnt) << 4;
    assign w_next_base      = ADDR_W'(w_blk_nxt) << 4;
    assign w_blocks_clamped = (ctrl_bus.msg_blocks > MAX_BLK) ? MAX_BLK : ctrl_bus.msg_blocks;

`ifdef SHA256_CTRL_ABORT_EN
    assign w_abort = ctrl_bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    // State and all outputs are registered together; strobes default low every cycle.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_blocks    <= '0;
            r_blk_cnt   <= '0;
            r_round_idx <= '0;
            r_read_en   <= 1'b0;
            r_read_addr <= '0;
            r_w_sel     <= 1'b0;
            r_hash_iv   <= 1'b0;
            r_work_load <= 1'b0;
            r_round_en  <= 1'b0;
            r_hash_add  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_read_en   <= 1'b0;
            r_read_addr <= '0;
            r_w_sel     <= 1'b0;
            r_hash_iv   <= 1'b0;
            r_work_load <= 1'b0;
            r_round_en  <= 1'b0;
            r_hash_add  <= 1'b0;
            r_done      <= 1'b0;

            if (w_abort && (r_state != S_IDLE)) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_round_idx <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_busy <= 1'b0;
                        if (ctrl_bus.start) begin
                            r_busy <= 1'b1;
                            if (ctrl_bus.msg_blocks == '0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state     <= S_INIT;
                                r_blocks    <= w_blocks_clamped;
                                r_blk_cnt   <= '0;
                                r_round_idx <= '0;
                                r_hash_iv   <= 1'b1;
                                r_read_en   <= 1'b1;
                                r_read_addr <= '0;
                            end
                        end
                    end

                    // Word 0 was fetched in INIT/LOAD; round 0 prefetches word 1.
                    S_INIT, S_LOAD: begin
                        r_state     <= S_ROUND;
                        r_round_idx <= '0;
                        r_round_en  <= 1'b1;
                        r_w_sel     <= 1'b1;
                        r_read_en   <= 1'b1;
                        r_read_addr <= w_base + ADDR_W'(1);
                    end

                    S_ROUND: begin
                        if (r_round_idx == LAST_ROUND) begin
                            r_state     <= S_UPDATE;
                            r_round_idx <= '0;
                            r_hash_add  <= 1'b1;
                        end else begin
                            r_round_idx <= w_round_nxt;
                            r_round_en  <= 1'b1;
                            r_w_sel     <= (w_round_nxt < 6'd16);
                            if (w_round_nxt < 6'd15) begin
                                r_read_en   <= 1'b1;
                                r_read_addr <= w_base + ADDR_W'(w_round_nxt) + ADDR_W'(1);
                            end
                        end
                    end

                    S_UPDATE: begin
                        r_blk_cnt <= w_blk_nxt;
                        if (w_blk_nxt == r_blocks) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_LOAD;
                            r_work_load <= 1'b1;
                            r_read_en   <= 1'b1;
                            r_read_addr <= w_next_base;
                        end
                    end

                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end

                    default: begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_round_idx <= '0;
                    end
                endcase
            end
        end
    end

    assign ctrl_bus.msg_read_en   = r_read_en;
    assign ctrl_bus.msg_read_addr = r_read_addr;
    assign ctrl_bus.round_idx     = r_round_idx;
    assign ctrl_bus.w_sel_msg     = r_w_sel;
    assign ctrl_bus.hash_iv       = r_hash_iv;
    assign ctrl_bus.work_load     = r_work_load;
    assign ctrl_bus.round_en      = r_round_en;
    assign ctrl_bus.hash_add      = r_hash_add;
    assign ctrl_bus.busy          = r_busy;
    assign ctrl_bus.done          = r_done;

endmodule
